// File: rtl/lfsr_chk_pkg.sv
// Shared state encoding, widths and the XNOR LFSR step (taps 7,4) for lfsr_seq_checker.
package lfsr_chk_pkg;
  localparam int LFSR_W = 8;
  localparam int TAP_HI = 7;
  localparam int TAP_LO = 4;
  localparam logic [LFSR_W-1:0] LOCKUP_VAL = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] x);
    return {x[LFSR_W-2:0], ~(x[TAP_HI] ^ x[TAP_LO])};
  endfunction
endpackage

// File: rtl/lfsr_seq_checker_popcount8.sv
// 8-bit combinational population count used to size bit errors on a misprediction.
module lfsr_popcount8
  import lfsr_chk_pkg::*;
(
  input  logic [LFSR_W-1:0] data,
  output logic [3:0]        count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < LFSR_W; i++) count = count + {3'b000, data[i]};
  end
endmodule

// File: rtl/lfsr_seq_checker.sv
// Tracks an 8-bit XNOR LFSR stream: acquires lock, flywheels through errors, counts them.
// Define LFSR_CHK_BITERR_EN to build the per-bit error counter (otherwise bit_err_count is 0).
module lfsr_seq_checker
  import lfsr_chk_pkg::*;
#(
  parameter int LOCK_COUNT  = 4,
  parameter int LOSS_THRESH = 3,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_valid,
  input  logic [LFSR_W-1:0]    data,
  input  logic                 clr,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 lockup_seen,
  output logic [ERR_CNT_W-1:0] bit_err_count
);
  localparam logic [3:0]           LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]           LOSS_N  = 4'(LOSS_THRESH);
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

  chk_state_e        state, state_nxt;
  logic [LFSR_W-1:0] pred, pred_nxt;
  logic [3:0]        match_cnt, match_nxt;
  logic [3:0]        miss_run, miss_nxt;
  logic              miss;
  logic              hit, is_lockup;

  assign hit       = (data == pred);
  assign is_lockup = (data == LOCKUP_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pred_nxt  = pred;
    match_nxt = match_cnt;
    miss_nxt  = miss_run;
    miss      = 1'b0;
    if (data_valid) begin
      case (state)
        HUNT: begin
          // 0xFF is the XNOR lock-up state and would reproduce itself; never seed from it
          if (!is_lockup) begin
            pred_nxt  = lfsr_next(data);
            match_nxt = '0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          if (hit) begin
            match_nxt = match_cnt + 4'd1;
            pred_nxt  = lfsr_next(data);
            if (match_nxt == LOCK_N) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else if (!is_lockup) begin
            pred_nxt  = lfsr_next(data);
            match_nxt = '0;
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // flywheel: keep stepping our own prediction rather than reseeding from bad data
          pred_nxt = lfsr_next(pred);
          if (hit) begin
            miss_nxt = '0;
          end else begin
            miss     = 1'b1;
            miss_nxt = miss_run + 4'd1;
            if (miss_nxt == LOSS_N) begin
              state_nxt = HUNT;
              match_nxt = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred        <= '0;
      match_cnt   <= '0;
      miss_run    <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      err_count   <= '0;
      lockup_seen <= 1'b0;
    end else begin
      pred      <= pred_nxt;
      match_cnt <= match_nxt;
      miss_run  <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= miss;
      // clear discards the old count but keeps an error landing in the same cycle
      if (clr)                      err_count <= miss ? CNT_ONE : '0;
      else if (miss && !(&err_count)) err_count <= err_count + CNT_ONE;
      if (data_valid && is_lockup) lockup_seen <= 1'b1;
      else if (clr)                lockup_seen <= 1'b0;
    end
  end

`ifdef LFSR_CHK_BITERR_EN
  logic [LFSR_W-1:0]  diff;
  logic [3:0]         pc;
  logic [ERR_CNT_W:0] bit_sum;

  assign diff = data ^ pred;
  lfsr_popcount8 u_popcnt (.data(diff), .count(pc));

  // one extra bit catches the carry so the add saturates instead of wrapping
  assign bit_sum = {1'b0, bit_err_count} + (ERR_CNT_W+1)'(pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bit_err_count <= '0;
    else if (clr)  bit_err_count <= miss ? ERR_CNT_W'(pc) : '0;
    else if (miss) bit_err_count <= bit_sum[ERR_CNT_W] ? '1 : bit_sum[ERR_CNT_W-1:0];
  end
`else
  assign bit_err_count = '0;
`endif
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed table plus hand sequences for lfsr_seq_checker; second instance covers saturation.
module tb_lfsr_seq_checker;
  logic        clk;
  logic        rst_n;
  logic        data_valid;
  logic [7:0]  data;
  logic        clr;

  logic        locked, err_pulse, lockup_seen;
  logic [15:0] err_count, bit_err_count;
  logic        s_locked, s_err_pulse, s_lockup_seen;
  logic [3:0]  s_err_count, s_bit_err_count;

  int total = 0;
  int pass  = 0;

  lfsr_seq_checker u_dut (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count),
    .lockup_seen(lockup_seen), .bit_err_count(bit_err_count)
  );

  lfsr_seq_checker #(.LOCK_COUNT(4), .LOSS_THRESH(15), .ERR_CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .data_valid(data_valid), .data(data), .clr(clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .err_count(s_err_count),
    .lockup_seen(s_lockup_seen), .bit_err_count(s_bit_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] tb_next(input logic [7:0] x);
    return {x[6:0], ~(x[7] ^ x[4])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    data_valid = v; data = d; clr = c;
    @(posedge clk);
    #1;
    data_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; data_valid = 1'b0; clr = 1'b0; data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic lock_seq;
    step(1, 8'h00, 0); step(1, 8'h01, 0); step(1, 8'h03, 0);
    step(1, 8'h07, 0); step(1, 8'h0F, 0);
  endtask

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        c;
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic        ls;
  } vec_t;

  vec_t vt [19];

  initial begin
    logic [7:0] p;
    // acquire, flywheel one error, lose lock on three misses, lock-up flag and clr priority
    vt[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vt[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vt[2]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vt[3]  = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0};
    vt[4]  = '{1'b1, 8'h0F, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    vt[5]  = '{1'b1, 8'h1F, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0};
    vt[6]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 16'd1, 1'b0};
    vt[7]  = '{1'b1, 8'h7C, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
    vt[8]  = '{1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
    vt[9]  = '{1'b1, 8'hF8, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
    vt[10] = '{1'b1, 8'hF1, 1'b0, 1'b1, 1'b0, 16'd1, 1'b0};
    vt[11] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 16'd2, 1'b0};
    vt[12] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 16'd3, 1'b0};
    vt[13] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 16'd4, 1'b0};
    vt[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0};
    vt[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};
    vt[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1};
    vt[17] = '{1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1};
    vt[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0};

    rst_n = 1'b0; data_valid = 1'b0; data = 8'h00; clr = 1'b0;
    #12;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err_pulse", 32'(err_pulse), 0);
    chk("rst_err_count", 32'(err_count), 0);
    chk("rst_lockup", 32'(lockup_seen), 0);
    chk("rst_bit_err", 32'(bit_err_count), 0);
    do_reset;

    for (int i = 0; i < 19; i++) begin
      step(vt[i].v, vt[i].d, vt[i].c);
      chk($sformatf("vec%0d_locked", i), 32'(locked), 32'(vt[i].lk));
      chk($sformatf("vec%0d_err_pulse", i), 32'(err_pulse), 32'(vt[i].ep));
      chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(vt[i].ec));
      chk($sformatf("vec%0d_lockup", i), 32'(lockup_seen), 32'(vt[i].ls));
    end

    // async reset in the middle of a lock with a pending error
    do_reset;
    lock_seq;
    step(1, 8'h00, 0);
    chk("midlock_err_count", 32'(err_count), 1);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_err_pulse", 32'(err_pulse), 0);
    chk("async_rst_err_count", 32'(err_count), 0);
    @(negedge clk); rst_n = 1'b1;

    // 0xFF in HUNT never seeds
    step(1, 8'hFF, 0); step(1, 8'hFF, 0); step(1, 8'hFF, 0);
    chk("ff_hunt_state", 32'(u_dut.state), 0);
    chk("ff_hunt_lockup", 32'(lockup_seen), 1);
    chk("ff_hunt_locked", 32'(locked), 0);
    step(0, 8'h00, 1);
    chk("ff_clr_lockup", 32'(lockup_seen), 0);

    // SYNC reseed on a mismatch restarts the match count
    do_reset;
    step(1, 8'h00, 0); step(1, 8'h01, 0); step(1, 8'h55, 0);
    p = tb_next(8'h55);
    for (int i = 0; i < 3; i++) begin
      step(1, p, 0); p = tb_next(p);
    end
    chk("reseed_not_yet", 32'(locked), 0);
    chk("reseed_no_pulse", 32'(err_pulse), 0);
    step(1, p, 0);
    chk("reseed_locked", 32'(locked), 1);
    chk("reseed_err_count", 32'(err_count), 0);

    // 0xFF mismatch in SYNC falls back to HUNT
    do_reset;
    step(1, 8'h00, 0); step(1, 8'hFF, 0);
    chk("sync_ff_state", 32'(u_dut.state), 0);
    chk("sync_ff_lockup", 32'(lockup_seen), 1);

    // bit errors: 0x3F vs 0x3E is 1 bit, 0x83 vs 0x7C is 8 bits
    do_reset;
    lock_seq;
    step(1, 8'h1F, 0);
    step(1, 8'h3F, 0);
    chk("biterr_pulse", 32'(err_pulse), 1);
    chk("biterr_err_count", 32'(err_count), 1);
`ifdef LFSR_CHK_BITERR_EN
    chk("biterr_one", 32'(bit_err_count), 1);
`else
    chk("biterr_one", 32'(bit_err_count), 0);
`endif
    step(1, 8'h83, 0);
    chk("biterr_err_count2", 32'(err_count), 2);
`ifdef LFSR_CHK_BITERR_EN
    chk("biterr_nine", 32'(bit_err_count), 9);
`else
    chk("biterr_nine", 32'(bit_err_count), 0);
`endif

    // saturation on the 4-bit instance: 14 misses, one hit, 6 more misses
    do_reset;
    lock_seq;
    chk("sat_locked", 32'(s_locked), 1);
    p = 8'h1F;
    for (int i = 0; i < 14; i++) begin
      step(1, p ^ 8'h01, 0); p = tb_next(p);
    end
    chk("sat_14_count", 32'(s_err_count), 14);
    chk("sat_14_locked", 32'(s_locked), 1);
    chk("sat_14_pulse", 32'(s_err_pulse), 1);
    step(1, p, 0); p = tb_next(p);
    chk("sat_hit_pulse", 32'(s_err_pulse), 0);
    for (int i = 0; i < 6; i++) begin
      step(1, p ^ 8'h01, 0); p = tb_next(p);
    end
    chk("sat_20_count", 32'(s_err_count), 15);
    chk("sat_20_locked", 32'(s_locked), 1);
`ifdef LFSR_CHK_BITERR_EN
    chk("sat_20_bit_err", 32'(s_bit_err_count), 15);
`else
    chk("sat_20_bit_err", 32'(s_bit_err_count), 0);
`endif
    step(1, p ^ 8'h01, 1);
    chk("sat_clr_err_count", 32'(s_err_count), 1);
`ifdef LFSR_CHK_BITERR_EN
    chk("sat_clr_bit_err", 32'(s_bit_err_count), 1);
`else
    chk("sat_clr_bit_err", 32'(s_bit_err_count), 0);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 8-bit pseudo-random stream from the board-level LFSR generator.
- Polynomial is XNOR feedback, taps bits 7 and 4: next(x) = {x[6:0], ~(x[7]^x[4])}.
- Predicts each next value, acquires lock, and flywheels through errors.
- Reports lock status, error pulses, a saturating error count, and a sticky flag for the 0xFF lock-up state.
- Drives LEDR/HEX status in the lab top level.

Parameters:
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (legal range 1..15).
- LOSS_THRESH, 3: consecutive mispredictions in LOCKED that drop lock (legal range 1..15).
- ERR_CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- data_valid  in  1  data qualifies this cycle; single-cycle strobe per LFSR step.
- data  in  8  LFSR value under test.
- clr  in  1  synchronous clear of err_count, bit_err_count and lockup_seen; does not affect the FSM.
- locked  out  1  high while the FSM is in LOCKED.
- err_pulse  out  1  one-cycle pulse on each misprediction in LOCKED.
- err_count  out  ERR_CNT_W  saturating count of LOCKED mispredictions.
- lockup_seen  out  1  sticky; set when a valid sample equals 0xFF.
- bit_err_count  out  ERR_CNT_W  saturating count of mismatched bits (see Optional Feature).

Behaviour:
- Reset (async):
  - state=HUNT, pred=0x00, match_cnt=0, miss_run=0.
  - All outputs 0.
- Idle: samples with data_valid=0 change nothing; err_pulse=0.
- FSM states HUNT, SYNC, LOCKED, encoded as 2 bits.
- HUNT:
  - valid & data!=0xFF -> pred<=next(data), match_cnt<=0, go SYNC.
  - valid & data==0xFF -> stay HUNT; 0xFF is never a seed.
- SYNC, valid & data==pred:
  - match_cnt++, pred<=next(data).
  - If match_cnt+1 == LOCK_COUNT -> go LOCKED, miss_run<=0.
- SYNC, valid & data!=pred:
  - If data!=0xFF -> reseed pred<=next(data), match_cnt<=0, stay SYNC.
  - If data==0xFF -> go HUNT.
  - No err_pulse in SYNC.
- LOCKED, valid & data==pred: pred<=next(pred), miss_run<=0.
- LOCKED, valid & data!=pred:
  - pred<=next(pred) (flywheel, no reseed).
  - err_pulse=1 next cycle; err_count+1, saturating at all-ones.
  - miss_run++; if miss_run+1 == LOSS_THRESH -> go HUNT, match_cnt<=0.
- Output timing:
  - locked, err_pulse and the counters are registered: they update the cycle after the sample edge.
  - locked deasserts the cycle after the LOSS_THRESH-th miss.
- lockup_seen:
  - Set on any valid 0xFF in any state.
  - Cleared only by clr or reset.
  - clr and a simultaneous set in the same cycle -> set wins.
- clr and a simultaneous error increment in the same cycle -> counter loads 1; clr takes priority over the old value.
- Reset mid-lock: returns to HUNT immediately; counters cleared.

Optional Feature:
- Macro: LFSR_CHK_BITERR_EN.
- Defined:
  - On each LOCKED misprediction, bit_err_count += popcount(data^pred) (0..8), saturating.
  - Same clr and reset rules as err_count.
- Undefined:
  - No popcount logic is built.
  - bit_err_count is tied to 0; the port stays present.

Decomposition:
- Package lfsr_chk_pkg:
  - state enum (HUNT=0, SYNC=1, LOCKED=2).
  - LFSR_W=8, TAP_HI=7, TAP_LO=4, LOCKUP_VAL=8'hFF.
  - function lfsr_next.
- Sub-module lfsr_popcount8 (8-bit combinational popcount, 4-bit output), instantiated only under LFSR_CHK_BITERR_EN.

Test Plan:
- Acquire lock:
  - Stimulus: reset, then valid stream 0x00,0x01,0x03,0x07,0x0F.
  - Response: locked=1 the cycle after 0x0F; err_count=0.
- Flywheel through one error:
  - Stimulus: locked on the sequence above, send 0x1F then 0x55 in place of 0x3E, then 0x7C,0xF8,0xF1.
  - Response: one err_pulse; err_count=1; locked stays 1; miss_run returns to 0 on 0x7C.
- Loss of lock:
  - Stimulus: locked, three consecutive wrong samples (0xAA,0xAA,0xAA).
  - Response: err_count=3; locked=0 the cycle after the third sample; FSM in HUNT.
- Lock-up value:
  - Stimulus: in HUNT send 0xFF x3.
  - Response: FSM stays HUNT, lockup_seen=1; pulse clr -> lockup_seen=0.
- Saturation and clr priority:
  - Stimulus: ERR_CNT_W=4, force 20 LOCKED errors (LOSS_THRESH=15, resync between bursts).
  - Response: err_count=0xF. Then clr coincident with an error -> err_count=1.
- Bit-error count with LFSR_CHK_BITERR_EN:
  - Stimulus: locked, expected 0x3E, send 0x3F.
  - Response: bit_err_count=1. Without the macro: always 0.
